cache_control: RTL and testbench
================================

Name: cache_control

Overview:
- Control FSM for the 2-way set-associative L1 cache. It drives every load, mux-select and data-in control of cache_datapath from CPU requests, datapath status and the physical-memory handshake.
- Sits between the LC-3b CPU memory port and cache_datapath/physical memory.
- Handles hits, clean and dirty misses, write-back and allocate.
- Keeps saturating hit and miss counters for performance bring-up.

Parameters:
- CNT_WIDTH, 16, width of the hit_count and miss_count saturating counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle request completion to CPU
- pmem_read  out  1  physical memory line read
- pmem_write  out  1  physical memory line write
- pmem_resp  in  1  physical memory completion pulse
- hit, hit2_out, valid1_out, valid2_out, dirty1_out, dirty2_out, lru_out  in  1 each  status from cache_datapath; lru_out = victim way (0=way1, 1=way2)
- load_tag1, load_tag2, load_valid1, load_valid2, load_data1, load_data2, load_lru, load_dirty1, load_dirty2  out  1 each  datapath array write enables
- valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in  out  1 each  datapath array write data
- writemux1_sel, writemux2_sel  out  1 each  0 = pmem_rdata line, 1 = CPU-merged line
- pmem_sel  out  1  0 = mem_address, 1 = victim {tag, index, 0000}
- pmem_write_sel  out  1  0 = way1 line, 1 = way2 line
- hit_count, miss_count  out  CNT_WIDTH  saturating statistics

Behaviour:
- States: IDLE_COMPARE, WRITEBACK, ALLOCATE. All outputs are decoded from state plus inputs (Moore/Mealy mix). The only registered state is the FSM state and the two counters.
- Reset (rst_n low, async): state goes to IDLE_COMPARE and the counters clear to 0. With no request, every output is 0.
- Request = mem_read | mem_write. mem_write takes priority if both are asserted; the read is ignored.
- IDLE_COMPARE, request and hit, same cycle:
  - mem_resp=1, load_lru=1.
  - lru_in = ~hit2_out, so the other way becomes the victim.
  - Write hit: load_dataN=1, writemuxN_sel=1, load_dirtyN=1, dirtyN_in=1 for the hit way (N=2 if hit2_out, else 1).
  - hit_count += 1, saturating at all-ones. Stay in IDLE_COMPARE.
- IDLE_COMPARE, request and miss:
  - miss_count += 1 (saturating), once per miss.
  - Victim v = lru_out. If valid_v & dirty_v, go to WRITEBACK; otherwise go to ALLOCATE.
  - mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_sel=1, pmem_write_sel=lru_out, held until pmem_resp.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_sel=0. Physical memory ignores address bits [3:0].
  - On pmem_resp, for victim way v: load_datav=1, writemuxv_sel=0, load_tagv=1, load_validv=1, validv_in=1, load_dirtyv=1, dirtyv_in=0.
  - Then go to IDLE_COMPARE. The retried request hits on the next cycle, so total miss latency = pmem latencies + 2 cycles.
- lru is not written during WRITEBACK or ALLOCATE, so the victim is stable throughout a miss.
- Request dropped mid-miss (protocol violation): the pending pmem transaction completes, then the FSM returns to IDLE_COMPARE. No mem_resp is issued. Counters are not re-incremented.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- Reset during WRITEBACK/ALLOCATE: pmem_read and pmem_write drop immediately; no array write occurs.
- Outputs are never X after reset. Unused load signals are 0.

Test Plan:
- Cold read at x1234 after reset (all invalid, lru=0) -> ALLOCATE (no WRITEBACK); pmem_read until pmem_resp; load_tag1=load_valid1=load_data1=1, writemux1_sel=0; next cycle hit, mem_resp=1, lru_in=1; miss_count=1, hit_count=1.
- Read x1234 again -> mem_resp in the first request cycle, no pmem activity; hit_count=2.
- Write x1236 with mem_byte_enable=2'b01 (hit way1) -> same cycle: mem_resp=1, load_data1=1, writemux1_sel=1, load_dirty1=1, dirty1_in=1.
- Fill way2 with tag x0A2 at the same index, then miss to a third tag with lru_out=0 and way1 dirty -> WRITEBACK: pmem_write=1, pmem_sel=1, pmem_write_sel=0 for 3 cycles until pmem_resp; then ALLOCATE into way1 with dirty1_in=0.
- Assert rst_n=0 mid-WRITEBACK -> pmem_write falls asynchronously; state IDLE_COMPARE; counters 0; no load_* pulse.
- CNT_WIDTH=4, 20 consecutive hits -> hit_count saturates at 4'hF; miss_count unchanged.

Source files
------------

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative L1 cache: hit service, dirty-victim
// write-back, line allocate, and saturating hit/miss statistics.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit,
    input  logic                 hit2_out,
    input  logic                 valid1_out,
    input  logic                 valid2_out,
    input  logic                 dirty1_out,
    input  logic                 dirty2_out,
    input  logic                 lru_out,
    output logic                 load_tag1,
    output logic                 load_tag2,
    output logic                 load_valid1,
    output logic                 load_valid2,
    output logic                 load_data1,
    output logic                 load_data2,
    output logic                 load_lru,
    output logic                 load_dirty1,
    output logic                 load_dirty2,
    output logic                 valid1_in,
    output logic                 valid2_in,
    output logic                 dirty1_in,
    output logic                 dirty2_in,
    output logic                 lru_in,
    output logic                 writemux1_sel,
    output logic                 writemux2_sel,
    output logic                 pmem_sel,
    output logic                 pmem_write_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE_COMPARE = 2'd0,
        WRITEBACK    = 2'd1,
        ALLOCATE     = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_nextState;
    logic [CNT_WIDTH-1:0]  r_hitCount;
    logic [CNT_WIDTH-1:0]  r_missCount;
    logic                  w_req;
    logic                  w_victimDirty;
    logic                  w_hitInc;
    logic                  w_missInc;

    assign w_req         = mem_read | mem_write;
    assign w_victimDirty = lru_out ? (valid2_out & dirty2_out) : (valid1_out & dirty1_out);
    assign hit_count     = r_hitCount;
    assign miss_count    = r_missCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_COMPARE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Outputs are held at 0 while reset is low so a held request cannot pulse any array write.
    always_comb begin
        w_nextState    = r_state;
        w_hitInc       = 1'b0;
        w_missInc      = 1'b0;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        load_tag1      = 1'b0;
        load_tag2      = 1'b0;
        load_valid1    = 1'b0;
        load_valid2    = 1'b0;
        load_data1     = 1'b0;
        load_data2     = 1'b0;
        load_lru       = 1'b0;
        load_dirty1    = 1'b0;
        load_dirty2    = 1'b0;
        valid1_in      = 1'b0;
        valid2_in      = 1'b0;
        dirty1_in      = 1'b0;
        dirty2_in      = 1'b0;
        lru_in         = 1'b0;
        writemux1_sel  = 1'b0;
        writemux2_sel  = 1'b0;
        pmem_sel       = 1'b0;
        pmem_write_sel = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                IDLE_COMPARE: begin
                    if (w_req && hit) begin
                        w_hitInc = 1'b1;
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hit2_out;
                        if (mem_write) begin
                            if (hit2_out) begin
                                load_data2    = 1'b1;
                                writemux2_sel = 1'b1;
                                load_dirty2   = 1'b1;
                                dirty2_in     = 1'b1;
                            end else begin
                                load_data1    = 1'b1;
                                writemux1_sel = 1'b1;
                                load_dirty1   = 1'b1;
                                dirty1_in     = 1'b1;
                            end
                        end
                    end else if (w_req) begin
                        w_missInc   = 1'b1;
                        w_nextState = w_victimDirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write     = 1'b1;
                    pmem_sel       = 1'b1;
                    pmem_write_sel = lru_out;
                    if (pmem_resp) begin
                        w_nextState = w_req ? ALLOCATE : IDLE_COMPARE;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        w_nextState = IDLE_COMPARE;
                        if (lru_out) begin
                            load_data2  = 1'b1;
                            load_tag2   = 1'b1;
                            load_valid2 = 1'b1;
                            valid2_in   = 1'b1;
                            load_dirty2 = 1'b1;
                        end else begin
                            load_data1  = 1'b1;
                            load_tag1   = 1'b1;
                            load_valid1 = 1'b1;
                            valid1_in   = 1'b1;
                            load_dirty1 = 1'b1;
                        end
                    end
                end
                default: w_nextState = IDLE_COMPARE;
            endcase
        end
    end

    // Statistics counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            if (w_hitInc && (r_hitCount != '1)) begin
                r_hitCount <= r_hitCount + CNT_ONE;
            end
            if (w_missInc && (r_missCount != '1)) begin
                r_missCount <= r_missCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: datapath status is driven by hand and every
// 1-bit control output is checked as one packed bus against hand-built masks.
module tb_cache_control;

    localparam int CW = 4;

    localparam logic [20:0] MEM_RESP   = 21'h1 << 20;
    localparam logic [20:0] PMEM_READ  = 21'h1 << 19;
    localparam logic [20:0] PMEM_WRITE = 21'h1 << 18;
    localparam logic [20:0] LD_TAG1    = 21'h1 << 17;
    localparam logic [20:0] LD_TAG2    = 21'h1 << 16;
    localparam logic [20:0] LD_VALID1  = 21'h1 << 15;
    localparam logic [20:0] LD_VALID2  = 21'h1 << 14;
    localparam logic [20:0] LD_DATA1   = 21'h1 << 13;
    localparam logic [20:0] LD_DATA2   = 21'h1 << 12;
    localparam logic [20:0] LD_LRU     = 21'h1 << 11;
    localparam logic [20:0] LD_DIRTY1  = 21'h1 << 10;
    localparam logic [20:0] LD_DIRTY2  = 21'h1 << 9;
    localparam logic [20:0] VALID1_IN  = 21'h1 << 8;
    localparam logic [20:0] VALID2_IN  = 21'h1 << 7;
    localparam logic [20:0] DIRTY1_IN  = 21'h1 << 6;
    localparam logic [20:0] DIRTY2_IN  = 21'h1 << 5;
    localparam logic [20:0] LRU_IN     = 21'h1 << 4;
    localparam logic [20:0] WMUX1      = 21'h1 << 3;
    localparam logic [20:0] WMUX2      = 21'h1 << 2;
    localparam logic [20:0] PMEM_SEL   = 21'h1 << 1;
    localparam logic [20:0] PMEM_WSEL  = 21'h1;

    localparam logic [20:0] FILL1 = PMEM_READ | LD_TAG1 | LD_VALID1 | LD_DATA1 | LD_DIRTY1 | VALID1_IN;
    localparam logic [20:0] FILL2 = PMEM_READ | LD_TAG2 | LD_VALID2 | LD_DATA2 | LD_DIRTY2 | VALID2_IN;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_read, mem_write, mem_resp;
    logic pmem_read, pmem_write, pmem_resp;
    logic hit, hit2_out, valid1_out, valid2_out, dirty1_out, dirty2_out, lru_out;
    logic load_tag1, load_tag2, load_valid1, load_valid2, load_data1, load_data2;
    logic load_lru, load_dirty1, load_dirty2;
    logic valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in;
    logic writemux1_sel, writemux2_sel, pmem_sel, pmem_write_sel;
    logic [CW-1:0] hit_count, miss_count;
    logic [20:0] ctrlBus;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign ctrlBus = {mem_resp, pmem_read, pmem_write, load_tag1, load_tag2, load_valid1,
                      load_valid2, load_data1, load_data2, load_lru, load_dirty1, load_dirty2,
                      valid1_in, valid2_in, dirty1_in, dirty2_in, lru_in, writemux1_sel,
                      writemux2_sel, pmem_sel, pmem_write_sel};

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit(hit), .hit2_out(hit2_out), .valid1_out(valid1_out), .valid2_out(valid2_out),
        .dirty1_out(dirty1_out), .dirty2_out(dirty2_out), .lru_out(lru_out),
        .load_tag1(load_tag1), .load_tag2(load_tag2), .load_valid1(load_valid1),
        .load_valid2(load_valid2), .load_data1(load_data1), .load_data2(load_data2),
        .load_lru(load_lru), .load_dirty1(load_dirty1), .load_dirty2(load_dirty2),
        .valid1_in(valid1_in), .valid2_in(valid2_in), .dirty1_in(dirty1_in),
        .dirty2_in(dirty2_in), .lru_in(lru_in), .writemux1_sel(writemux1_sel),
        .writemux2_sel(writemux2_sel), .pmem_sel(pmem_sel), .pmem_write_sel(pmem_write_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns after that.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 0; mem_write = 0; pmem_resp = 0;
        hit = 0; hit2_out = 0; valid1_out = 0; valid2_out = 0;
        dirty1_out = 0; dirty2_out = 0; lru_out = 0;
        #12;
        compared++;
        if (ctrlBus !== 21'h0) begin
            $display("[TB] FAIL reset_ctrl got %h exp %h", ctrlBus, 21'h0); mismatched++;
        end
        compared++;
        if ({hit_count, miss_count} !== 8'h00) begin
            $display("[TB] FAIL reset_counts got %h exp %h", {hit_count, miss_count}, 8'h00); mismatched++;
        end
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_cold_read();
        mem_read = 1; #1;
        compared++;
        if (ctrlBus !== 21'h0) begin
            $display("[TB] FAIL cold_compare got %h exp %h", ctrlBus, 21'h0); mismatched++;
        end
        for (int i = 0; i < 2; i++) begin
            nextCycle(); #1;
            compared++;
            if (ctrlBus !== PMEM_READ) begin
                $display("[TB] FAIL cold_alloc_wait got %h exp %h", ctrlBus, PMEM_READ); mismatched++;
            end
        end
        compared++;
        if (miss_count !== 4'd1) begin
            $display("[TB] FAIL cold_miss_count got %0d exp 1", miss_count); mismatched++;
        end
        pmem_resp = 1; #1;
        compared++;
        if (ctrlBus !== FILL1) begin
            $display("[TB] FAIL cold_fill got %h exp %h", ctrlBus, FILL1); mismatched++;
        end
        nextCycle();
        pmem_resp = 0; hit = 1; valid1_out = 1; #1;
        compared++;
        if (ctrlBus !== (MEM_RESP | LD_LRU | LRU_IN)) begin
            $display("[TB] FAIL cold_retry_hit got %h exp %h", ctrlBus, MEM_RESP | LD_LRU | LRU_IN); mismatched++;
        end
        nextCycle();
        mem_read = 0; hit = 0; #1;
        compared++;
        if ({ctrlBus, hit_count, miss_count} !== {21'h0, 4'd1, 4'd1}) begin
            $display("[TB] FAIL cold_after got %h/%0d/%0d exp 0/1/1", ctrlBus, hit_count, miss_count); mismatched++;
        end
    endtask

    task automatic test_read_hit();
        mem_read = 1; hit = 1; #1;
        compared++;
        if (ctrlBus !== (MEM_RESP | LD_LRU | LRU_IN)) begin
            $display("[TB] FAIL read_hit got %h exp %h", ctrlBus, MEM_RESP | LD_LRU | LRU_IN); mismatched++;
        end
        nextCycle();
        mem_read = 0; hit = 0; #1;
        compared++;
        if (hit_count !== 4'd2) begin
            $display("[TB] FAIL read_hit_count got %0d exp 2", hit_count); mismatched++;
        end
    endtask

    task automatic test_write_hit();
        logic [20:0] expBus;
        expBus = MEM_RESP | LD_LRU | LRU_IN | LD_DATA1 | WMUX1 | LD_DIRTY1 | DIRTY1_IN;
        mem_write = 1; hit = 1; #1;
        compared++;
        if (ctrlBus !== expBus) begin
            $display("[TB] FAIL write_hit_way1 got %h exp %h", ctrlBus, expBus); mismatched++;
        end
        nextCycle();
        mem_write = 0; hit = 0; dirty1_out = 1; #1;
        compared++;
        if (hit_count !== 4'd3) begin
            $display("[TB] FAIL write_hit_count got %0d exp 3", hit_count); mismatched++;
        end
    endtask

    task automatic test_write_priority();
        logic [20:0] expBus;
        expBus = MEM_RESP | LD_LRU | LD_DATA2 | WMUX2 | LD_DIRTY2 | DIRTY2_IN;
        mem_read = 1; mem_write = 1; hit = 1; hit2_out = 1; valid2_out = 1; #1;
        compared++;
        if (ctrlBus !== expBus) begin
            $display("[TB] FAIL write_prio_way2 got %h exp %h", ctrlBus, expBus); mismatched++;
        end
        nextCycle();
        mem_read = 0; mem_write = 0; hit = 0; hit2_out = 0; dirty2_out = 1; #1;
    endtask

    task automatic test_writeback(input logic way);
        logic [20:0] wbBus;
        logic [20:0] fillBus;
        logic [20:0] hitBus;
        wbBus   = PMEM_WRITE | PMEM_SEL | (way ? PMEM_WSEL : 21'h0);
        fillBus = way ? FILL2 : FILL1;
        hitBus  = MEM_RESP | LD_LRU | (way ? 21'h0 : LRU_IN);
        mem_read = 1; lru_out = way; #1;
        compared++;
        if (ctrlBus !== 21'h0) begin
            $display("[TB] FAIL wb%0d_compare got %h exp %h", way, ctrlBus, 21'h0); mismatched++;
        end
        for (int i = 0; i < 3; i++) begin
            nextCycle(); #1;
            compared++;
            if (ctrlBus !== wbBus) begin
                $display("[TB] FAIL wb%0d_hold got %h exp %h", way, ctrlBus, wbBus); mismatched++;
            end
        end
        pmem_resp = 1; #1;
        compared++;
        if (ctrlBus !== wbBus) begin
            $display("[TB] FAIL wb%0d_resp got %h exp %h", way, ctrlBus, wbBus); mismatched++;
        end
        nextCycle();
        pmem_resp = 0; #1;
        compared++;
        if (ctrlBus !== PMEM_READ) begin
            $display("[TB] FAIL wb%0d_alloc got %h exp %h", way, ctrlBus, PMEM_READ); mismatched++;
        end
        pmem_resp = 1; #1;
        compared++;
        if (ctrlBus !== fillBus) begin
            $display("[TB] FAIL wb%0d_fill got %h exp %h", way, ctrlBus, fillBus); mismatched++;
        end
        nextCycle();
        pmem_resp = 0; hit = 1; hit2_out = way; #1;
        compared++;
        if (ctrlBus !== hitBus) begin
            $display("[TB] FAIL wb%0d_retry got %h exp %h", way, ctrlBus, hitBus); mismatched++;
        end
        nextCycle();
        mem_read = 0; hit = 0; hit2_out = 0; #1;
    endtask

    task automatic test_stray_resp();
        pmem_resp = 1; #1;
        compared++;
        if (ctrlBus !== 21'h0) begin
            $display("[TB] FAIL stray_resp got %h exp %h", ctrlBus, 21'h0); mismatched++;
        end
        nextCycle();
        pmem_resp = 0; #1;
        compared++;
        if ({ctrlBus, hit_count, miss_count} !== {21'h0, 4'd6, 4'd3}) begin
            $display("[TB] FAIL stray_after got %h/%0d/%0d exp 0/6/3", ctrlBus, hit_count, miss_count); mismatched++;
        end
    endtask

    task automatic test_reset_mid_wb();
        mem_write = 1; lru_out = 0; #1;
        nextCycle(); #1;
        compared++;
        if ({ctrlBus, miss_count} !== {PMEM_WRITE | PMEM_SEL, 4'd4}) begin
            $display("[TB] FAIL rst_wb_enter got %h/%0d exp %h/4", ctrlBus, miss_count, PMEM_WRITE | PMEM_SEL); mismatched++;
        end
        #1;
        rst_n = 0; hit = 1; pmem_resp = 1; #1;
        compared++;
        if ({ctrlBus, hit_count, miss_count} !== {21'h0, 4'd0, 4'd0}) begin
            $display("[TB] FAIL rst_wb_async got %h/%0d/%0d exp 0/0/0", ctrlBus, hit_count, miss_count); mismatched++;
        end
        nextCycle();
        mem_write = 0; hit = 0; pmem_resp = 0;
        rst_n = 1;
        nextCycle();
        compared++;
        if (ctrlBus !== 21'h0) begin
            $display("[TB] FAIL rst_wb_idle got %h exp %h", ctrlBus, 21'h0); mismatched++;
        end
    endtask

    task automatic test_saturation();
        mem_read = 1; hit = 1;
        for (int i = 1; i <= 20; i++) begin
            nextCycle();
            if (i == 14) begin
                compared++;
                if (hit_count !== 4'hE) begin
                    $display("[TB] FAIL sat_before got %h exp %h", hit_count, 4'hE); mismatched++;
                end
            end
        end
        mem_read = 0; hit = 0; #1;
        compared++;
        if ({hit_count, miss_count} !== {4'hF, 4'h0}) begin
            $display("[TB] FAIL sat_final got %h/%h exp F/0", hit_count, miss_count); mismatched++;
        end
    endtask

    task automatic test_drop_mid_miss();
        mem_read = 1; dirty1_out = 0; lru_out = 0; #1;
        nextCycle();
        mem_read = 0; #1;
        compared++;
        if ({ctrlBus, miss_count} !== {PMEM_READ, 4'd1}) begin
            $display("[TB] FAIL drop_alloc got %h/%0d exp %h/1", ctrlBus, miss_count, PMEM_READ); mismatched++;
        end
        pmem_resp = 1; #1;
        compared++;
        if ({mem_resp, pmem_read} !== 2'b01) begin
            $display("[TB] FAIL drop_resp got %b exp 01", {mem_resp, pmem_read}); mismatched++;
        end
        nextCycle();
        pmem_resp = 0; #1;
        compared++;
        if ({ctrlBus, hit_count, miss_count} !== {21'h0, 4'hF, 4'd1}) begin
            $display("[TB] FAIL drop_idle got %h/%h/%0d exp 0/F/1", ctrlBus, hit_count, miss_count); mismatched++;
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_write_priority();
        test_writeback(1'b0);
        test_writeback(1'b1);
        test_stray_resp();
        test_reset_mid_wb();
        test_saturation();
        test_drop_mid_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
